// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline-stage register.
//   pipe_state_t   : occupancy state of a stage (EMPTY / BUSY / FULL)
//   CTRL_W_DEFAULT : default width of the control bundle
//   CTRL_*         : bit positions of individual control flags within the bundle
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam int unsigned CTRL_W_DEFAULT = 9;

  localparam int unsigned CTRL_REGWRITE = 0;
  localparam int unsigned CTRL_MEMWRITE = 1;
  localparam int unsigned CTRL_MEMREAD  = 2;
  localparam int unsigned CTRL_MEMTOREG = 3;
  localparam int unsigned CTRL_ALUSRC   = 4;
  localparam int unsigned CTRL_BRANCH   = 5;
  localparam int unsigned CTRL_JUMP     = 6;
  localparam int unsigned CTRL_ALUOP_LO = 7;
  localparam int unsigned CTRL_ALUOP_HI = 8;

endpackage

// File: rtl/pipe_slot.sv
// One payload + control register entry of a pipeline stage.
//   clk, reset     : clock (rising edge), asynchronous active-low reset
//   load           : capture d_data/d_ctrl at the next edge
//   clear          : zero the entry at the next edge (wins over load)
//   d_data, d_ctrl : next payload / control bundle
//   q_data, q_ctrl : held payload / control bundle
module pipe_slot #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_data <= '0;
      q_ctrl <= '0;
    end else if (clear) begin
      q_data <= '0;
      q_ctrl <= '0;
    end else if (load) begin
      q_data <= d_data;
      q_ctrl <= d_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline-stage register carrying an opaque payload and
// a control bundle, with stall (back-pressure) and flush (bubble insertion).
//   clk, reset            : clock (rising edge), asynchronous active-low reset
//   flush                 : synchronous kill of every held beat
//   in_valid/in_ready     : upstream handshake
//   in_data/in_ctrl       : upstream payload / control bundle
//   out_valid/out_ready   : downstream handshake
//   out_data/out_ctrl     : payload / control bundle to downstream
// SKID=1 adds a second entry so in_ready is a register output; SKID=0 keeps a
// single entry with in_ready derived combinationally from out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = CTRL_W_DEFAULT,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
);

  pipe_state_t       state, state_nxt;
  logic              out_valid_r, in_ready_r;
  logic              in_fire, out_fire;
  logic              main_load, main_clr, main_from_skid;
  logic              skid_load, skid_clr;
  logic [DATA_W-1:0] main_d_data, skid_q_data;
  logic [CTRL_W-1:0] main_d_ctrl, skid_q_ctrl;

  assign out_valid = out_valid_r;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid_r & out_ready;

  always_comb begin
    state_nxt      = state;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
      main_clr  = 1'b1;
      skid_clr  = 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt = BUSY;
            main_load = 1'b1;
          end
        end
        BUSY: begin
          // With SKID=0, in_fire while BUSY already implies out_fire.
          if (in_fire && (out_fire || SKID == 0)) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            state_nxt = FULL;
            skid_load = 1'b1;
          end else if (out_fire) begin
            // Zero the drained entry so a bubble never carries live ctrl bits.
            state_nxt = EMPTY;
            main_clr  = 1'b1;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_nxt      = BUSY;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          state_nxt = EMPTY;
          main_clr  = 1'b1;
          skid_clr  = 1'b1;
        end
      endcase
    end
  end

  assign main_d_data = main_from_skid ? skid_q_data : in_data;
  assign main_d_ctrl = main_from_skid ? skid_q_ctrl : in_ctrl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state       <= state_nxt;
      out_valid_r <= (state_nxt != EMPTY);
      in_ready_r  <= (state_nxt != FULL);
    end
  end

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk    (clk),
    .reset  (reset),
    .load   (main_load),
    .clear  (main_clr),
    .d_data (main_d_data),
    .d_ctrl (main_d_ctrl),
    .q_data (out_data),
    .q_ctrl (out_ctrl)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
      ) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load   (skid_load),
        .clear  (skid_clr),
        .d_data (in_data),
        .d_ctrl (in_ctrl),
        .q_data (skid_q_data),
        .q_ctrl (skid_q_ctrl)
      );
      assign in_ready = in_ready_r;
    end else begin : g_noskid
      assign skid_q_data = '0;
      assign skid_q_ctrl = '0;
      assign in_ready    = out_ready | ~out_valid_r;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 and a SKID=0 instance driven with the
// same stimulus, each compared against a FIFO-occupancy reference model, plus
// a directed vector table for the skid/flush corner cases.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = 32;
  localparam int CW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic          s_in_ready, s_out_valid;
  logic [DW-1:0] s_out_data;
  logic [CW-1:0] s_out_ctrl;
  logic          p_in_ready, p_out_valid;
  logic [DW-1:0] p_out_data;
  logic [CW-1:0] p_out_ctrl;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_skid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_pass (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(p_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(p_out_valid), .out_ready(out_ready), .out_data(p_out_data), .out_ctrl(p_out_ctrl)
  );

  int checks = 0;
  int errors = 0;

  // Reference models: queue of held beats {ctrl,data}; capacity 2 (skid) / 1 (pass).
  // zN = outputs known to be zero while empty (after reset or flush).
  logic [DW+CW-1:0] q1[$];
  logic [DW+CW-1:0] q0[$];
  bit z1, z0;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          fl;
    logic          ev;
    logic          er;
    logic          cd;
    logic [DW-1:0] ed;
    logic [CW-1:0] ec;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic iv, logic [DW-1:0] d, logic ordy, logic fl,
                              logic ev, logic er, logic cd, logic [DW-1:0] ed,
                              logic [CW-1:0] ec);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.ev = ev; v.er = er; v.cd = cd; v.ed = ed; v.ec = ec;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic iv, logic [DW-1:0] d, logic [CW-1:0] c, logic ordy, logic fl);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    #1;
  endtask

  task automatic check_models();
    chk("s_out_valid", s_out_valid, q1.size() > 0);
    chk("s_in_ready", s_in_ready, q1.size() < 2);
    if (q1.size() > 0) begin
      chk("s_out_data", s_out_data, q1[0][DW-1:0]);
      chk("s_out_ctrl", s_out_ctrl, q1[0][DW+CW-1:DW]);
    end else if (z1) begin
      chk("s_zero_data", s_out_data, 0);
      chk("s_zero_ctrl", s_out_ctrl, 0);
    end
    chk("p_out_valid", p_out_valid, q0.size() > 0);
    chk("p_in_ready", p_in_ready, (q0.size() == 0) || out_ready);
    if (q0.size() > 0) begin
      chk("p_out_data", p_out_data, q0[0][DW-1:0]);
      chk("p_out_ctrl", p_out_ctrl, q0[0][DW+CW-1:DW]);
    end else if (z0) begin
      chk("p_zero_data", p_out_data, 0);
      chk("p_zero_ctrl", p_out_ctrl, 0);
    end
  endtask

  task automatic advance();
    bit f1i, f1o, f0i, f0o, fl;
    logic [DW+CW-1:0] beat;
    fl   = flush;
    beat = {in_ctrl, in_data};
    f1o  = (q1.size() > 0) && out_ready;
    f1i  = in_valid && (q1.size() < 2);
    f0o  = (q0.size() > 0) && out_ready;
    f0i  = in_valid && ((q0.size() == 0) || out_ready);
    @(posedge clk);
    if (fl) begin
      q1.delete(); q0.delete();
      z1 = 1'b1; z0 = 1'b1;
    end else begin
      if (f1o) void'(q1.pop_front());
      if (f1i) begin q1.push_back(beat); z1 = 1'b0; end
      if (f0o) void'(q0.pop_front());
      if (f0i) begin q0.push_back(beat); z0 = 1'b0; end
    end
    @(negedge clk);
  endtask

  task automatic cycle(logic iv, logic [DW-1:0] d, logic [CW-1:0] c, logic ordy, logic fl);
    drive(iv, d, c, ordy, fl);
    check_models();
    advance();
  endtask

  initial begin
    reset = 1'b0;
    z1 = 1'b1; z0 = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);

    // Reset held for three cycles, then release with nothing offered.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_models();
    end
    reset = 1'b1;
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    check_models();

    // Directed skid / flush sequence on the SKID=1 instance.
    tbl[0]  = mk(1, 32'hA, 0, 0,  0, 1, 1, 32'h0, 9'h000);
    tbl[1]  = mk(1, 32'hB, 0, 0,  1, 1, 1, 32'hA, 9'h1FF);
    tbl[2]  = mk(1, 32'hC, 0, 0,  1, 0, 1, 32'hA, 9'h1FF);
    tbl[3]  = mk(1, 32'hC, 0, 0,  1, 0, 1, 32'hA, 9'h1FF);
    tbl[4]  = mk(1, 32'hC, 1, 0,  1, 0, 1, 32'hA, 9'h1FF);
    tbl[5]  = mk(1, 32'hC, 1, 0,  1, 1, 1, 32'hB, 9'h1FF);
    tbl[6]  = mk(0, 32'h0, 1, 0,  1, 1, 1, 32'hC, 9'h1FF);
    tbl[7]  = mk(0, 32'h0, 1, 0,  0, 1, 0, 32'h0, 9'h000);
    tbl[8]  = mk(1, 32'hA, 0, 0,  0, 1, 0, 32'h0, 9'h000);
    tbl[9]  = mk(1, 32'hB, 0, 0,  1, 1, 1, 32'hA, 9'h1FF);
    tbl[10] = mk(1, 32'hC, 0, 1,  1, 0, 1, 32'hA, 9'h1FF);
    tbl[11] = mk(0, 32'h0, 0, 0,  0, 1, 1, 32'h0, 9'h000);
    tbl[12] = mk(0, 32'h0, 1, 0,  0, 1, 1, 32'h0, 9'h000);
    tbl[13] = mk(1, 32'hD, 0, 0,  0, 1, 1, 32'h0, 9'h000);
    tbl[14] = mk(1, 32'hE, 1, 1,  1, 1, 1, 32'hD, 9'h1FF);
    tbl[15] = mk(0, 32'h0, 1, 0,  0, 1, 1, 32'h0, 9'h000);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].iv, tbl[i].d, 9'h1FF, tbl[i].ordy, tbl[i].fl);
      chk("tbl_out_valid", s_out_valid, tbl[i].ev);
      chk("tbl_in_ready", s_in_ready, tbl[i].er);
      if (tbl[i].cd) begin
        chk("tbl_out_data", s_out_data, tbl[i].ed);
        chk("tbl_out_ctrl", s_out_ctrl, tbl[i].ec);
      end
      check_models();
      advance();
    end

    // Back-to-back streaming with downstream always ready.
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 32'h10 + DW'(k), 9'h1FF, 1'b1, 1'b0);
      chk("stream_s_in_ready", s_in_ready, 1);
      chk("stream_p_in_ready", p_in_ready, 1);
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Async reset asserted between edges while a beat is held.
    cycle(1'b1, 32'h55, 9'h0AA, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check_models();
    #2;
    reset = 1'b0;
    #1;
    chk("async_s_out_valid", s_out_valid, 0);
    chk("async_p_out_valid", p_out_valid, 0);
    chk("async_s_in_ready", s_in_ready, 1);
    chk("async_s_out_data", s_out_data, 0);
    chk("async_s_out_ctrl", s_out_ctrl, 0);
    q1.delete(); q0.delete();
    z1 = 1'b1; z0 = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Randomised traffic with occasional stalls and flushes.
    for (int n = 0; n < 3000; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), DW'($urandom), CW'($urandom),
            1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    check_models();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic, parametrised pipeline-stage register that replaces the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque data bus and a separate control-signal bus between stages.
- Uses a valid/ready handshake, with stall (back-pressure) and flush (bubble insertion).
- In SKID mode, a second entry registers in_ready, which breaks the combinational ready path through the pipeline.

Parameters:
DATA_W, 32, width of datapath payload (PC, operands, ALU result, write-register index, concatenated)
CTRL_W, 9, width of control-signal bundle (RegWrite, MemRead, branch/jump flags, ...)
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry, combinational in_ready

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset, asynchronous, active-low
flush  in  1  synchronous kill of all held beats (branch/jump taken)
in_valid  in  1  upstream beat present
in_ready  out  1  stage can accept beat this cycle
in_data  in  DATA_W  upstream payload
in_ctrl  in  CTRL_W  upstream control bundle
out_valid  out  1  beat present for downstream
out_ready  in  1  downstream accepts beat
out_data  out  DATA_W  payload to downstream
out_ctrl  out  CTRL_W  control bundle to downstream

Behaviour:
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (reset==0, async): state EMPTY; out_valid=0; out_data=0; out_ctrl=0; skid contents=0; in_ready=1 (SKID=1 only).
- Latency: a beat accepted at edge N appears on out_* immediately after edge N (1 cycle).
- While out_valid=1 and out_ready=0, out_data and out_ctrl are held stable.
- State machine (SKID=1), with main and skid entries:
  - EMPTY (out_valid=0, in_ready=1): in_fire -> BUSY, main<=in.
  - BUSY (out_valid=1, in_ready=1):
    - in_fire & out_fire -> BUSY, main<=in.
    - in_fire & !out_fire -> FULL, skid<=in.
    - !in_fire & out_fire -> EMPTY.
    - otherwise hold.
  - FULL (out_valid=1, in_ready=0): out_fire -> BUSY, main<=skid. Otherwise hold.
- in_ready is a registered output: 1 in EMPTY/BUSY, 0 in FULL.
- Beat order is strictly FIFO. No beat is lost or duplicated.
- SKID=0:
  - Only EMPTY/BUSY states exist.
  - in_ready = out_ready | !out_valid, combinational.
  - in_fire loads main; !in_fire & out_fire -> EMPTY.
- Flush (synchronous, highest priority below reset):
  - Next state is EMPTY.
  - main and skid data/ctrl are cleared to 0; out_valid=0 from the next cycle.
  - An in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle counts as delivered.
- Ctrl zeroing guarantees that a bubble carries no RegWrite/MemWrite even if downstream ignores out_valid.
- Async reset asserted mid-transfer: all beats are dropped, outputs go to reset values immediately, and the stage resumes in EMPTY at the first edge after deassertion.
- Widths: no arithmetic. Payload and ctrl are passed bit-exact.

Decomposition:
- Package pipe_pkg:
  - state enum {EMPTY, BUSY, FULL}.
  - Default CTRL_W constant.
  - Per-stage ctrl bit-index constants, e.g. CTRL_REGWRITE=0, CTRL_MEMWRITE=1.
- Sub-module pipe_slot: one data+ctrl register with load and clear.
  - Instantiated once for main.
  - Instantiated a second time for skid via generate when SKID=1.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles -> out_valid=0, out_data=0, out_ctrl=0, in_ready=1 (SKID=1). Release reset with in_valid=0 -> state unchanged.
- Streaming: out_ready=1; send in_data=0x00000010..0x00000014 back-to-back with in_ctrl=9'h1FF -> same 5 values on out_data, one per cycle, 1-cycle delay, in_ready stays 1.
- Stall/skid: out_ready=0; send 0xA, 0xB, then 0xC -> in_ready=0 after 0xB accepted, 0xC held upstream, out_data=0xA stable. Raise out_ready -> 0xA, 0xB, 0xC delivered in order.
- Flush while FULL: main=0xA, skid=0xB, assert flush with in_valid=1 (0xC) -> next cycle out_valid=0, out_ctrl=0, in_ready=1, and 0xC never appears.
- Async reset mid-stream: reset=0 asserted between edges while out_valid=1 -> out_valid=0 immediately, without waiting for a clock edge.
- SKID=0 instance: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle. out_ready=1 -> in_ready=1 combinationally, and pass-through continues at 1 beat/cycle.
